data_mem_ctr: RTL and testbench

Data-memory controller: the responder on the memory-stage interface of the RISC-V pipeline. It accepts one load or store request at a time from the memory stage and holds data in an internal word-organised array with byte-lane writes. Read data is returned right-aligned and zero-filled; the requesting stage does any sign or zero extension. A programmable wait-state count models slow memory, and a busy indication lets the pipeline stall.

---
 rtl/data_mem_ctr.sv | 264 ++++++++++++++++++++++++++
 tb/tb_data_mem_ctr.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctr.sv
// data_mem_ctr
//   Data-memory responder for the memory stage of the RISC-V pipeline.
//   It accepts one load or store at a time and holds a word-organised array
//   with byte-lane writes. A fixed number of wait states models slow memory.
//   Load data comes back right-aligned and zero-filled.
//
//   Build option: define DATA_MEM_CTR_ERR_EN to enable request checking.
//     With it, these requests are rejected: size 3, misaligned accesses,
//     addresses below the base, and indices past the array. A rejected
//     request answers straight away with o_err and leaves memory untouched.
//     Without it, o_err stays low. Misaligned addresses are masked to
//     alignment, size 3 acts as a word access, and the index wraps
//     modulo DEPTH_WORDS.
//
//   Ports
//     clk      in   single clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     i_req    in   request valid (sampled only while idle)
//     i_addr   in   byte address
//     i_val    in   store data, right-aligned
//     i_op     in   0 = load, 1 = store
//     i_size   in   0 = byte, 1 = halfword, 2 = word
//     o_ready  out  high only while idle
//     o_val    out  load data, valid with o_done
//     o_done   out  one-cycle completion pulse
//     o_err    out  request rejected, valid with o_done
//     o_stall  out  inverse of o_ready
//
//   state | meaning
//   IDLE  | waiting for a request; i_req accepted here only
//   WAIT  | wait-state down-counter running; memory access on exit
//   RESP  | one-cycle response: o_done high, o_val/o_err valid

module data_mem_ctr #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_val,
  input  logic        i_op,
  input  logic [1:0]  i_size,
  output logic        o_ready,
  output logic [31:0] o_val,
  output logic        o_done,
  output logic        o_err,
  output logic        o_stall
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic             op_q, op_d;
  logic [1:0]       size_q, size_d;
  logic             err_q, err_d;
  logic [31:0]      rval_q, rval_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             in_idle;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdat;
  logic             sel_op;
  logic [1:0]       sel_size;

  logic [31:0]      word_off;
  logic [IDX_W-1:0] mem_idx;
  logic [1:0]       eff_size;
  logic [1:0]       eff_lo;
  logic             req_err;

  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;
  logic             do_access;
  logic             mem_we;

  // In IDLE the request is decoded straight from the inputs. This lets a
  // zero-wait access and the error decision both happen on the acceptance
  // edge. In WAIT, the latched copy is used.
  assign in_idle  = (state_q == ST_IDLE);
  assign sel_addr = in_idle ? i_addr : addr_q;
  assign sel_wdat = in_idle ? i_val  : wdat_q;
  assign sel_op   = in_idle ? i_op   : op_q;
  assign sel_size = in_idle ? i_size : size_q;

`ifdef DATA_MEM_CTR_ERR_EN
  logic [32:0] off_ext;
  logic        below_base;

  // The 33-bit subtraction borrow flags an address below the base.
  // A direct compare against a zero base would be constant.
  assign off_ext    = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
  assign below_base = off_ext[32];
  assign word_off   = off_ext[31:0] >> 2;
  assign mem_idx    = IDX_W'(word_off);

  always_comb begin
    eff_size = sel_size;
    eff_lo   = sel_addr[1:0];
    case (sel_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = sel_addr[0];
      SZ_WORD: req_err = (sel_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (below_base || (word_off >= DEPTH_WORDS)) begin
      req_err = 1'b1;
    end
  end
`else
  assign word_off = (sel_addr - BASE_ADDR) >> 2;
  assign mem_idx  = IDX_W'(word_off % DEPTH_WORDS);
  assign req_err  = 1'b0;

  always_comb begin
    eff_size = (sel_size == 2'd3) ? SZ_WORD : sel_size;
    case (eff_size)
      SZ_BYTE: eff_lo = sel_addr[1:0];
      SZ_HALF: eff_lo = {sel_addr[1], 1'b0};
      default: eff_lo = 2'b00;
    endcase
  end
`endif

  // Replicate store data across all lanes so the byte enables alone pick
  // the destination lane.
  always_comb begin
    be    = 4'b0000;
    wdata = sel_wdat;
    case (eff_size)
      SZ_BYTE: begin
        be    = 4'b0001 << eff_lo;
        wdata = {4{sel_wdat[7:0]}};
      end
      SZ_HALF: begin
        be    = eff_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sel_wdat[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // The read is asynchronous, so the old word is captured before the
  // write on the same edge takes effect.
  assign rd_word  = mem_q[mem_idx];
  assign rd_shift = rd_word >> {eff_lo, 3'b000};

  always_comb begin
    case (eff_size)
      SZ_BYTE: load_data = {24'h0, rd_shift[7:0]};
      SZ_HALF: load_data = {16'h0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    op_d      = op_q;
    size_d    = size_q;
    err_d     = 1'b0;
    rval_d    = 32'h0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          addr_d = i_addr;
          wdat_d = i_val;
          op_d   = i_op;
          size_d = i_size;
          if (req_err) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d   = ST_RESP;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        // The count is loaded with WAIT_CYCLES, so leaving when it reads 1
        // places the access on edge E0 + WAIT_CYCLES.
        if (cnt_q <= CNT_W'(1)) begin
          state_d   = ST_RESP;
          cnt_d     = '0;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (do_access && !sel_op) begin
      rval_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      wdat_q  <= 32'h0;
      op_q    <= 1'b0;
      size_q  <= 2'b00;
      err_q   <= 1'b0;
      rval_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      op_q    <= op_d;
      size_q  <= size_d;
      err_q   <= err_d;
      rval_q  <= rval_d;
    end
  end

  // The array is not reset. Qualifying the write with rst_n keeps a
  // pending store from committing while reset is held.
  assign mem_we = do_access && sel_op && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[mem_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_ready = in_idle;
  assign o_stall = !in_idle;
  assign o_done  = (state_q == ST_RESP);
  assign o_val   = rval_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctr.sv
`timescale 1ns/1ps
module tb_data_mem_ctr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_val = 32'h0;
  logic        i_op = 1'b0;
  logic [1:0]  i_size = 2'd0;
  logic        o_ready;
  logic [31:0] o_val;
  logic        o_done;
  logic        o_err;
  logic        o_stall;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef DATA_MEM_CTR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int WAITC = 2;
  localparam int ELAT  = ERR_EN ? 0 : WAITC;

  data_mem_ctr #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(WAITC),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_val  (i_val),
    .i_op   (i_op),
    .i_size (i_size),
    .o_ready(o_ready),
    .o_val  (o_val),
    .o_done (o_done),
    .o_err  (o_err),
    .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [31:0] val;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  typedef struct packed {
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wval;
    logic [31:0] eval;
    logic        eerr;
    logic [3:0]  elat;
  } txn_t;

  exp_t sb[$];

  function automatic txn_t mk(input logic op, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wval,
                              input logic [31:0] eval, input logic eerr,
                              input int elat);
    txn_t t;
    t.op = op; t.size = size; t.addr = addr; t.wval = wval;
    t.eval = eval; t.eerr = eerr; t.elat = 4'(elat);
    return t;
  endfunction

  // Returns at the falling edge right after the acceptance edge E0.
  task automatic drive_req(input logic op, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wval);
    int guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: o_ready=%b required 1", o_ready);
    end
    i_req = 1'b1; i_op = op; i_size = size; i_addr = addr; i_val = wval;
    @(posedge clk);
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] v, output logic e,
                           output int lat, output bit to);
    lat = 0; to = 1'b1; v = 32'h0; e = 1'b0;
    while (lat < 20) begin
      if (o_done) begin
        v = o_val; e = o_err; to = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_txn(input txn_t t, output logic [31:0] v, output logic e,
                         output int lat, output bit to);
    exp_t x;
    x.val = t.eval; x.err = t.eerr; x.lat = t.elat;
    sb.push_back(x);
    drive_req(t.op, t.size, t.addr, t.wval);
    wait_resp(v, e, lat, to);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", o_ready); end
    n_chk++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", o_stall); end
    n_chk++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", o_done); end
    n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", o_err); end
    n_chk++; if (o_val !== 32'h0) begin n_fail++; $display("FAIL reset_val: got %h required 0", o_val); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    txn_t tbl[$];
    logic [31:0] v; logic e; int lat; bit to; exp_t x;
    tbl.push_back(mk(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, WAITC));
    for (int k = 0; k < tbl.size(); k++) begin
      run_txn(tbl[k], v, e, lat, to);
      x = sb.pop_front();
      n_chk++;
      if (to || v !== x.val || e !== x.err || lat !== int'(x.lat)) begin
        n_fail++;
        $display("FAIL word[%0d]: got val=%h err=%b lat=%0d timeout=%0b, required val=%h err=%b lat=%0d",
                 k, v, e, lat, to, x.val, x.err, x.lat);
      end
    end
  endtask

  task automatic test_subword();
    txn_t tbl[$];
    logic [31:0] v; logic e; int lat; bit to; exp_t x;
    tbl.push_back(mk(1'b1, 2'd0, 32'h11, 32'hFFFFFFAA, 32'h0, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd0, 32'h11, 32'h0, 32'h000000AA, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd0, 32'h13, 32'h0, 32'h000000DE, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd1, 32'h10, 32'h0, 32'h0000AAEF, 1'b0, WAITC));
    tbl.push_back(mk(1'b1, 2'd2, 32'h14, 32'h0, 32'h0, 1'b0, WAITC));
    tbl.push_back(mk(1'b1, 2'd1, 32'h16, 32'hFFFF1234, 32'h0, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd2, 32'h14, 32'h0, 32'h12340000, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd0, 32'h16, 32'h0, 32'h00000034, 1'b0, WAITC));
    for (int k = 0; k < tbl.size(); k++) begin
      run_txn(tbl[k], v, e, lat, to);
      x = sb.pop_front();
      n_chk++;
      if (to || v !== x.val || e !== x.err || lat !== int'(x.lat)) begin
        n_fail++;
        $display("FAIL subword[%0d]: got val=%h err=%b lat=%0d timeout=%0b, required val=%h err=%b lat=%0d",
                 k, v, e, lat, to, x.val, x.err, x.lat);
      end
    end
  endtask

  task automatic test_bounds();
    txn_t tbl[$];
    logic [31:0] v; logic e; int lat; bit to; exp_t x;
    tbl.push_back(mk(1'b1, 2'd2, 32'h000, 32'hCAFEF00D, 32'h0, 1'b0, WAITC));
    tbl.push_back(mk(1'b1, 2'd2, 32'hFFC, 32'h13572468, 32'h0, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd2, 32'hFFC, 32'h0, 32'h13572468, 1'b0, WAITC));
    tbl.push_back(mk(1'b0, 2'd2, 32'h13, 32'h0, ERR_EN ? 32'h0 : 32'hDEADAAEF, ERR_EN, ELAT));
    tbl.push_back(mk(1'b0, 2'd1, 32'h11, 32'h0, ERR_EN ? 32'h0 : 32'h0000AAEF, ERR_EN, ELAT));
    tbl.push_back(mk(1'b0, 2'd3, 32'h10, 32'h0, ERR_EN ? 32'h0 : 32'hDEADAAEF, ERR_EN, ELAT));
    tbl.push_back(mk(1'b0, 2'd2, 32'h1000, 32'h0, ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN, ELAT));
    tbl.push_back(mk(1'b1, 2'd0, 32'h1003, 32'h00000055, 32'h0, ERR_EN, ELAT));
    tbl.push_back(mk(1'b0, 2'd2, 32'h000, 32'h0, ERR_EN ? 32'hCAFEF00D : 32'h55FEF00D, 1'b0, WAITC));
    for (int k = 0; k < tbl.size(); k++) begin
      run_txn(tbl[k], v, e, lat, to);
      x = sb.pop_front();
      n_chk++;
      if (to || v !== x.val || e !== x.err || lat !== int'(x.lat)) begin
        n_fail++;
        $display("FAIL bounds[%0d]: got val=%h err=%b lat=%0d timeout=%0b, required val=%h err=%b lat=%0d",
                 k, v, e, lat, to, x.val, x.err, x.lat);
      end
    end
  endtask

  task automatic test_held();
    exp_t x;
    logic [31:0] v; logic e; int lat; bit to;
    logic exp_stall, exp_done;
    int guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 20) begin @(negedge clk); guard++; end
    x.val = 32'hDEADAAEF; x.err = 1'b0; x.lat = 4'(WAITC);
    // Ten cycles of held i_req admit requests at E0, E0+4 and E0+8.
    for (int n = 0; n < 3; n++) sb.push_back(x);
    i_req = 1'b1; i_op = 1'b0; i_size = 2'd2; i_addr = 32'h10; i_val = 32'h0;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_stall = ((k % 4) != 3);
      exp_done  = ((k % 4) == 2);
      n_chk++;
      if (o_stall !== exp_stall || o_done !== exp_done) begin
        n_fail++;
        $display("FAIL held_cycle[%0d]: got stall=%b done=%b required stall=%b done=%b",
                 k, o_stall, o_done, exp_stall, exp_done);
      end
      if (o_done) begin
        x = sb.pop_front();
        n_chk++;
        if (o_val !== x.val || o_err !== x.err) begin
          n_fail++;
          $display("FAIL held_resp[%0d]: got val=%h err=%b required val=%h err=%b",
                   k, o_val, o_err, x.val, x.err);
        end
      end
    end
    i_req = 1'b0;
    wait_resp(v, e, lat, to);
    x = sb.pop_front();
    n_chk++;
    if (to || v !== x.val || e !== x.err || lat !== 1) begin
      n_fail++;
      $display("FAIL held_last: got val=%h err=%b lat=%0d timeout=%0b required val=%h err=%b lat=1",
               v, e, lat, to, x.val, x.err);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (o_ready !== 1'b1 || o_done !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL held_drain: got ready=%b done=%b pending=%0d required ready=1 done=0 pending=0",
               o_ready, o_done, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    txn_t t;
    logic [31:0] v; logic e; int lat; bit to; exp_t x;
    int done_seen = 0;
    t = mk(1'b1, 2'd2, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, WAITC);
    run_txn(t, v, e, lat, to);
    x = sb.pop_front();
    n_chk++;
    if (to || v !== x.val || e !== x.err || lat !== int'(x.lat)) begin
      n_fail++;
      $display("FAIL midrst_pre: got val=%h err=%b lat=%0d timeout=%0b required val=%h err=%b lat=%0d",
               v, e, lat, to, x.val, x.err, x.lat);
    end
    drive_req(1'b1, 2'd2, 32'h20, 32'h12345678);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (o_ready !== 1'b1 || o_stall !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got ready=%b stall=%b done=%b required ready=1 stall=0 done=0",
               o_ready, o_stall, o_done);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_done) done_seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_done) done_seen++;
    end
    n_chk++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL midrst_nodone: got %0d done pulses required 0", done_seen);
    end
    t = mk(1'b0, 2'd2, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, WAITC);
    run_txn(t, v, e, lat, to);
    x = sb.pop_front();
    n_chk++;
    if (to || v !== x.val || e !== x.err || lat !== int'(x.lat)) begin
      n_fail++;
      $display("FAIL midrst_load: got val=%h err=%b lat=%0d timeout=%0b required val=%h err=%b lat=%0d",
               v, e, lat, to, x.val, x.err, x.lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_bounds();
    test_held();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
